// File: rtl/ordena9_seq.sv
// Sequencer around the 9-input sorter: collects 9 elements from a valid/ready stream,
// pulses the sorter reset, captures the sorted result and streams it out index 0 first.
module ordena9_seq #(
    parameter int unsigned W       = 8,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [9*W-1:0] ord_entrada,
    output logic           ord_rst,
    input  logic [9*W-1:0] ord_saida,
    input  logic           ord_flag,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           busy,
    output logic           err
);

    localparam int unsigned N  = 9;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CLR,
        ST_WAIT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       idx_q;
    logic [TW-1:0]       tmo_q;
    logic [TW-1:0]       settle_q;
    logic                first_q;
    logic [N-1:0][W-1:0] elem_q;
    logic [N-1:0][W-1:0] res_q;
    logic [N-1:0][W-1:0] saida;
    logic                in_ready_q;
    logic                ord_rst_q;
    logic [W-1:0]        out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic                err_q;

    logic [CW-1:0]       cnt_inc;
    logic [CW-1:0]       idx_inc;
    logic [TW-1:0]       tmo_inc;

    assign saida   = ord_saida;
    assign cnt_inc = cnt_q + CW'(1);
    assign idx_inc = idx_q + CW'(1);
    assign tmo_inc = tmo_q + TW'(1);

    assign in_ready    = in_ready_q;
    assign ord_entrada = elem_q;
    assign ord_rst     = ord_rst_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign err         = err_q;

    // Control FSM; ord_rst is high exactly while in CLR or during a timeout retry cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            settle_q    <= '0;
            first_q     <= 1'b0;
            elem_q      <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b0;
            ord_rst_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ord_rst_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        elem_q[cnt_q] <= in_data;
                        busy_q        <= 1'b1;
                        if (cnt_q == CW'(N - 1)) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            ord_rst_q  <= 1'b1;
                            state_q    <= ST_CLR;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end

                ST_CLR: begin
                    tmo_q   <= '0;
                    first_q <= 1'b1;
                    state_q <= ST_WAIT;
                end

                // The first cycle after a sorter reset may still show the old flag.
                ST_WAIT: begin
                    first_q <= 1'b0;
                    if (!first_q && ord_flag) begin
                        if (SETTLE == 0) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            settle_q <= TW'(SETTLE);
                            state_q  <= ST_SETTLE;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_q     <= 1'b1;
                        ord_rst_q <= 1'b1;
                        tmo_q     <= '0;
                        first_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_inc;
                    end
                end

                ST_SETTLE: begin
                    if (settle_q <= TW'(1)) begin
                        settle_q <= '0;
                        state_q  <= ST_CAPTURE;
                    end else begin
                        settle_q <= settle_q - TW'(1);
                    end
                end

                ST_CAPTURE: begin
                    res_q       <= saida;
                    idx_q       <= '0;
                    out_data_q  <= saida[0];
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    state_q     <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        if (idx_q == CW'(N - 1)) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            cnt_q       <= '0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_LOAD;
                        end else begin
                            idx_q      <= idx_inc;
                            out_data_q <= res_q[idx_inc];
                            out_last_q <= (idx_inc == CW'(N - 1));
                        end
                    end
                end

                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ordena9_seq.sv
// Bench for ordena9_seq: behavioural sorter and stream model with a per-cycle compare
// process, plus directed jobs whose sorted outputs are pinned by literal tables.
module tb_ordena9_seq;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] ord_entrada;
    logic        ord_rst;
    logic [71:0] ord_saida;
    logic        ord_flag;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;

    bit allow_retry = 0;
    bit m_err_exp   = 0;

    int srt_delay = 5;
    bit srt_stale = 0;
    bit srt_never = 0;

    logic [7:0] got [$];
    bit         got_last [$];

    ordena9_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ord_entrada(ord_entrada),
        .ord_rst    (ord_rst),
        .ord_saida  (ord_saida),
        .ord_flag   (ord_flag),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [71:0] sort_desc(input logic [71:0] x);
        logic [7:0] a [9];
        logic [7:0] t;
        logic [71:0] r;
        for (int i = 0; i < 9; i++) a[i] = x[i*8 +: 8];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] < a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sorter model: results appear srt_delay cycles after its reset pulse.
    initial begin
        int srt_cnt;
        int stale_left;
        srt_cnt = 0;
        stale_left = 0;
        ord_flag = 1'b0;
        ord_saida = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                ord_flag = 1'b0; srt_cnt = 0; stale_left = 0;
            end else if (ord_rst) begin
                srt_cnt = srt_delay;
                stale_left = srt_stale ? 2 : 0;
                ord_flag = srt_stale ? ord_flag : 1'b0;
            end else if (srt_cnt > 0) begin
                if (stale_left > 0) stale_left--;
                if (stale_left == 0) ord_flag = 1'b0;
                srt_cnt--;
                if (srt_cnt == 0 && !srt_never) begin
                    ord_saida = sort_desc(ord_entrada);
                    ord_flag = 1'b1;
                end
            end
        end
    end

    // Per-cycle compare against a stream-level model: accepted inputs, pending sorted results.
    task automatic monitor();
        logic [7:0]  elem [9];
        logic [7:0]  q [$];
        logic [71:0] pe;
        logic [71:0] s;
        logic [7:0]  prev_data;
        logic        prev_last;
        int cnt;
        bit job, rst_seen, exp_rst, prev_stall;
        cnt = 0; job = 0; rst_seen = 1; exp_rst = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        for (int i = 0; i < 9; i++) elem[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 9; i++) pe[i*8 +: 8] = elem[i];
            if (rst_seen) begin
                chk("reset_vals", 128'({in_ready, ord_rst, out_valid, out_last, busy, err,
                                        out_data, ord_entrada}), 128'(0));
            end else begin
                chk("in_ready", 128'(in_ready), 128'(!job));
                chk("busy", 128'(busy), 128'(job || cnt != 0));
                chk("ord_entrada", 128'(ord_entrada), 128'(pe));
                if (!allow_retry) begin
                    chk("ord_rst", 128'(ord_rst), 128'(exp_rst));
                    chk("err", 128'(err), 128'(m_err_exp));
                end else if (exp_rst) begin
                    chk("ord_rst", 128'(ord_rst), 128'(1));
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("out_valid_idle", 128'(out_valid), 128'(0));
                    end else begin
                        chk("out_data", 128'(out_data), 128'(q[0]));
                        chk("out_last", 128'(out_last), 128'(q.size() == 1));
                    end
                end
                if (prev_stall)
                    chk("stall_hold", 128'({out_valid, out_last, out_data}),
                        128'({1'b1, prev_last, prev_data}));
            end
            if (reset) begin
                rst_seen = 1; cnt = 0; job = 0; exp_rst = 0; prev_stall = 0;
                q.delete();
                for (int i = 0; i < 9; i++) elem[i] = '0;
            end else begin
                rst_seen = 0;
                exp_rst = 0;
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
                if (in_valid && in_ready) begin
                    elem[cnt] = in_data;
                    cnt++;
                    if (cnt == 9) begin
                        for (int i = 0; i < 9; i++) pe[i*8 +: 8] = elem[i];
                        s = sort_desc(pe);
                        for (int i = 0; i < 9; i++) q.push_back(s[i*8 +: 8]);
                        cnt = 0; job = 1; exp_rst = 1;
                    end
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    got.push_back(out_data);
                    got_last.push_back(out_last);
                    void'(q.pop_front());
                    if (q.size() == 0) job = 0;
                end
            end
        end
    endtask

    task automatic wait_accept();
        int b;
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 300) begin @(negedge clk); b++; end
        chk("accept_wait", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic load9(input logic [7:0] v [9], input bit gaps, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                in_valid = 1'b0; in_data = 8'h5A;
                repeat (g) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1; in_data = v[i];
            wait_accept();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int stall_idx, input int stall_len);
        int b;
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                out_ready = 1'b0;
                repeat (stall_len) begin @(posedge clk); #1; end
            end
            out_ready = 1'b1;
            b = 0;
            @(negedge clk);
            while (!out_valid && b < 400) begin @(negedge clk); b++; end
            chk("drain_wait", 128'(out_valid), 128'(1));
            if (!out_valid) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_got(input int base, input logic [7:0] e [9]);
        chk("got_count", 128'(got.size() - base), 128'(9));
        for (int i = 0; i < 9; i++)
            if (base + i < got.size()) begin
                chk("got_data", 128'(got[base+i]), 128'(e[i]));
                chk("got_last", 128'(got_last[base+i]), 128'(i == 8));
            end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_err_exp = 1'b0;
        @(negedge clk);
        chk("rst_busy", 128'({busy, out_valid, in_ready}), 128'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v [9];
        logic [7:0] e [9];
        int base;
        int b;
        int n;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Job 1: continuous valid.
        base = got.size();
        v = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd5, 8'd4};
        load9(v, 1'b0, 9);
        drain(9, -1, 0);
        e = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        check_got(base, e);

        // Job 2: all equal, junk valid while busy, first output held with ready low.
        base = got.size();
        v = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        load9(v, 1'b0, 9);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hEE;
        b = 0;
        @(negedge clk);
        while (!out_valid && b < 400) begin @(negedge clk); b++; end
        chk("wait_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain(9, -1, 0);
        e = v;
        check_got(base, e);

        // Job 3: input gaps, duplicates, 5-cycle stall at idx 3.
        base = got.size();
        v = '{8'h10, 8'h80, 8'h10, 8'hFF, 8'h00, 8'h33, 8'h80, 8'h01, 8'h7F};
        load9(v, 1'b1, 9);
        drain(9, 3, 5);
        e = '{8'hFF, 8'h80, 8'h80, 8'h7F, 8'h33, 8'h10, 8'h10, 8'h01, 8'h00};
        check_got(base, e);

        // Job 4: sorter silent -> timeout, retry pulse, then recovery with err sticky.
        chk("err_before", 128'(err), 128'(0));
        allow_retry = 1'b1;
        srt_never = 1'b1;
        base = got.size();
        v = '{8'd5, 8'd5, 8'd1, 8'd9, 8'd0, 8'd3, 8'd3, 8'd7, 8'd2};
        load9(v, 1'b0, 9);
        b = 0;
        @(negedge clk);
        while (!ord_rst && b < 50) begin @(negedge clk); b++; end
        chk("clr_pulse", 128'(ord_rst), 128'(1));
        n = 0;
        while (!err && n < 200) begin @(negedge clk); n++; end
        chk("tmo_cycles", 128'(n), 128'(65));
        chk("retry_rst", 128'(ord_rst), 128'(1));
        srt_never = 1'b0;
        m_err_exp = 1'b1;
        @(posedge clk); #1;
        drain(9, -1, 0);
        allow_retry = 1'b0;
        e = '{8'd9, 8'd7, 8'd5, 8'd5, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
        check_got(base, e);
        chk("err_sticky", 128'(err), 128'(1));

        // Job 5: reset at cnt=4 in LOAD and at idx=5 in DRAIN, then a clean job.
        load9(v, 1'b0, 4);
        pulse_reset();
        load9(v, 1'b0, 9);
        drain(5, -1, 0);
        pulse_reset();
        base = got.size();
        v = '{8'h31, 8'h04, 8'hC8, 8'h77, 8'h04, 8'hFE, 8'h5B, 8'h90, 8'h12};
        load9(v, 1'b0, 9);
        drain(9, -1, 0);
        e = '{8'hFE, 8'hC8, 8'h90, 8'h77, 8'h5B, 8'h31, 8'h12, 8'h04, 8'h04};
        check_got(base, e);

        // Job 6: flag still high from the previous job must not trigger a stale capture.
        srt_stale = 1'b1;
        srt_delay = 6;
        base = got.size();
        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'h55};
        load9(v, 1'b0, 9);
        drain(9, -1, 0);
        e = '{8'h55, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        check_got(base, e);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ordena9_seq.md
Name: ordena9_seq

Overview:
- Sequencer wrapped around the 9-input sorter.
- Upstream side: collects 9 bytes from a valid/ready stream and holds them stable on the sorter's parallel input bus.
- Sorter side: issues a one-cycle sorter reset pulse, then waits for the sorter's done flag and captures its 9 results.
- Downstream side: streams the captured results out serially, index 0 first, with valid/ready and a last marker.

Parameters:
- W, 8, data width per element; must match the sorter.
- SETTLE, 1, extra cycles waited after ord_flag rises before capturing ord_saida.
- TIMEOUT, 64, max cycles in WAIT before err is raised; legal range 16..255.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  W  input element.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- ord_entrada  out  9*W  element k on bits [k*W+W-1 : k*W]; drives the sorter input bus.
- ord_rst  out  1  sorter reset pulse.
- ord_saida  in  9*W  sorter result, same packing; index 0 is the largest value (descending order).
- ord_flag  in  1  sorter result-ready flag.
- out_data  out  W  result element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_last  out  1  high with the 9th (index 8) result.
- busy  out  1  high in any state other than LOAD with cnt==0.
- err  out  1  sticky timeout error; cleared only by reset.

Behaviour:
- Reset values: in_ready=0, ord_entrada=0, ord_rst=0, out_data=0, out_valid=0, out_last=0, busy=0, err=0, state=LOAD, cnt=0.
- Reset applies mid-operation with the same effect: a partial load or drain is discarded.
- State LOAD:
  - in_ready=1 from the first cycle after reset is released.
  - A transfer occurs when in_valid && in_ready; the transferred in_data is written to element cnt, then cnt increments.
  - The 9th accepted transfer (cnt==8) moves to CLR with in_ready=0 from the next cycle.
  - Elements are registered and held constant until the next LOAD begins.
- State CLR:
  - ord_rst=1 for exactly one cycle, then go to WAIT.
  - Timeout counter cleared.
- State WAIT:
  - ord_flag is ignored during the first cycle after CLR (stale flag).
  - After that, ord_flag==1 moves to SETTLE with settle counter = SETTLE.
  - If SETTLE==0, go straight to CAPTURE.
  - Timeout counter increments each cycle. When it reaches TIMEOUT: err<=1, ord_rst pulses one cycle, and the state returns to WAIT with the counter cleared (retry). The retry is unbounded; err stays set.
- State SETTLE: decrement the settle counter; at 0 go to CAPTURE.
- State CAPTURE: register all 9 elements of ord_saida into the result buffer, set idx=0, go to DRAIN.
- State DRAIN:
  - out_valid=1 and out_data=result[idx]; out_last=(idx==8).
  - On out_valid && out_ready: idx increments. If idx==8, out_valid<=0 next cycle and go to LOAD with cnt=0.
  - While out_ready=0, out_data/out_valid/out_last are held stable.
  - in_ready=0 throughout DRAIN; no overlap of load and drain.
- Latency: at least 1 (CLR) + sorter time + SETTLE + 1 (CAPTURE) cycles from the 9th input accept to first out_valid.
- in_valid while in_ready=0 is ignored, not stored.
- No arithmetic on data; values pass through unmodified. Duplicate values are legal.

Test Plan:
- Reset, then load 9,3,7,1,8,2,6,5,4 with continuous valid; model the sorter -> one ord_rst pulse, then out stream 9,8,7,6,5,4,3,2,1 with out_last only on the value 1.
- Load all 0xAA -> nine outputs of 0xAA; in_ready low from the cycle after the 9th accept until the cycle after the last drain.
- Random in_valid gaps plus out_ready held low for 5 cycles on idx 3 -> no lost or duplicated element; out_data stable while stalled.
- Sorter model never raises ord_flag -> err=1 after 64 WAIT cycles, ord_rst re-pulsed; then raise flag -> normal drain, err stays 1.
- Assert reset at cnt=4 in LOAD and at idx=5 in DRAIN -> all outputs return to reset values next cycle; a subsequent full load sorts correctly.
- ord_flag left high from the previous run -> ignored in the first WAIT cycle; capture only after settle.
